// File: rtl/exec_muldiv_sequencer.sv
// Iterative RV32M multiply/divide beside the execute ALU: 33-cycle start-to-done, 1-cycle divide fast paths.
// Stalls the pipeline while busy; o_done is a one-cycle strobe, flush aborts in any state.
module exec_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_result;

    logic               w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fast_res;
    logic               w_div_zero, w_div_ovf, w_fast, w_start, w_last;
    logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_calc_res;

    // Unsigned ops carry clear sign flags, so the sign fix below needs no per-op gating.
    assign w_is_div   = i_op[2];
    assign w_a_signed = i_op[2] ? !i_op[0] : (i_op != 3'b011);
    assign w_b_signed = i_op[2] ? !i_op[0] : !i_op[1];
    assign w_a_neg    = w_a_signed & i_src_a[WIDTH-1];
    assign w_b_neg    = w_b_signed & i_src_b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -i_src_a : i_src_a;
    assign w_b_mag    = w_b_neg ? -i_src_b : i_src_b;

    assign w_div_zero = (i_src_b == '0);
    assign w_div_ovf  = !i_op[0] && (i_src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_src_b);
    assign w_fast     = w_is_div && (w_div_zero || w_div_ovf);
    assign w_fast_res = w_div_zero ? (i_op[1] ? i_src_a : '1) : (i_op[1] ? '0 : i_src_a);

    assign w_start = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_last  = (r_cnt == CW'(WIDTH-1));

    // Multiply: low half holds the multiplier, shifted out as the product shifts in.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: remainder:quotient register, quotient bits enter at the bottom.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};
    assign w_qbit    = !w_diff[WIDTH];
    assign w_div_nxt = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};

    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
    assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quo     = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    assign w_rem     = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_calc_res = w_rem;
        case (r_op)
            3'b000:                 w_calc_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_calc_res = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_calc_res = w_quo;
            default:                w_calc_res = w_rem;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_state_nxt = w_fast ? S_DONE : S_CALC;
                S_CALC:  if (w_last)  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy  = (r_state != S_IDLE);
        o_done  = (r_state == S_DONE) && !i_flush;
        o_stall = w_start || ((r_state == S_CALC) && !i_flush);
    end

    assign o_result = r_result;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_start) begin
            r_op    <= i_op;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_fast) begin
                r_result <= w_fast_res;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                r_opnd <= w_is_div ? w_b_mag : w_a_mag;
            end
        end else if ((r_state == S_CALC) && !i_flush) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_result <= w_calc_res;
        end
    end
endmodule

// File: tb/tb_exec_muldiv_sequencer.sv
// Randomized and directed bench for exec_muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_exec_muldiv_sequencer;
    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start, i_flush;
    logic [2:0]        i_op;
    logic [WIDTH-1:0]  i_src_a, i_src_b;
    logic              o_stall, o_busy, o_done;
    logic [WIDTH-1:0]  o_result;

    int n_checks = 0;
    int n_errors = 0;

    exec_muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_op(i_op),
        .i_src_a(i_src_a), .i_src_b(i_src_b), .i_flush(i_flush),
        .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] pv, qv, rv;
        logic a_s, b_s;
        a_s = op[2] ? !op[0] : (op != 3'd3);
        b_s = op[2] ? !op[0] : (op == 3'd0 || op == 3'd1);
        sa = a_s ? {{32{a[31]}}, a} : {32'b0, a};
        sb = b_s ? {{32{b[31]}}, b} : {32'b0, b};
        if (!op[2]) begin
            p  = sa * sb;
            pv = p;
            return (op == 3'd0) ? pv[31:0] : pv[63:32];
        end
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (a_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return op[1] ? rv[31:0] : qv[31:0];
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit toggle);
        logic [31:0] exp_res;
        int exp_lat, lat, n_stall, n_busy;
        exp_res = ref_model(op, a, b);
        exp_lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : WIDTH + 1;
        @(negedge clk);
        i_op = op; i_src_a = a; i_src_b = b; i_start = 1'b1;
        #1;
        check("busy_c0", {31'b0, o_busy}, 32'd0);
        n_stall = int'(o_stall);
        n_busy  = 0;
        lat     = 0;
        while (!o_done && lat < 100) begin
            @(negedge clk);
            i_start = toggle ? 1'($urandom) : 1'b0;
            i_src_a = $urandom;
            i_src_b = $urandom;
            i_op    = 3'($urandom);
            #1;
            lat++;
            n_stall += int'(o_stall);
            n_busy  += int'(o_busy);
        end
        i_start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", o_result, exp_res);
        check("stall_cycles", 32'(n_stall), 32'(exp_lat));
        check("busy_cycles", 32'(n_busy), 32'(exp_lat));
        @(negedge clk);
        #1;
        check("done_pulse", {31'b0, o_done}, 32'd0);
        check("idle_after", {31'b0, o_busy}, 32'd0);
        check("result_hold", o_result, exp_res);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit saw_done;
        rst_n = 1'b0; i_start = 1'b0; i_flush = 1'b0; i_op = 3'd0; i_src_a = '0; i_src_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_stall", {31'b0, o_stall}, 32'd0);
        check("rst_result", o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 1'b0);
        run_op(3'd6, 32'd5, 32'd0, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Flush a divide at cycle 10, then restart a multiply at cycle 12.
        saw_done = 1'b0;
        @(negedge clk);
        i_op = 3'd4; i_src_a = 32'd1000; i_src_b = 32'd3; i_start = 1'b1;
        repeat (9) begin
            @(negedge clk);
            i_start = 1'b0;
            #1;
            if (o_done) saw_done = 1'b1;
        end
        @(negedge clk);
        i_flush = 1'b1;
        #1;
        if (o_done) saw_done = 1'b1;
        check("flush_stall", {31'b0, o_stall}, 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        if (o_done) saw_done = 1'b1;
        check("flush_busy", {31'b0, o_busy}, 32'd0);
        check("flush_no_done", {31'b0, saw_done}, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 1'b0);

        // Flush and start together: flush wins.
        @(negedge clk);
        i_op = 3'd0; i_src_a = 32'd9; i_src_b = 32'd9; i_start = 1'b1; i_flush = 1'b1;
        #1;
        check("fs_stall", {31'b0, o_stall}, 32'd0);
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        #1;
        check("fs_busy", {31'b0, o_busy}, 32'd0);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        i_op = 3'd0; i_src_a = 32'd11; i_src_b = 32'd13; i_start = 1'b1;
        repeat (20) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, o_busy}, 32'd0);
        check("arst_done", {31'b0, o_done}, 32'd0);
        check("arst_result", o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick_operand(), pick_operand(), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/exec_muldiv_sequencer.md
Name: exec_muldiv_sequencer

Overview:
Iterative RV32M multiply/divide unit with its own sequencing FSM, attached beside the execute-stage ALU. Takes the already-forwarded execute operands plus funct3 and runs a 32-step shift-add multiply or restoring divide. Holds the pipeline stalled while computing and presents a one-cycle-valid result that the execute/memory register captures in place of the ALU result. Responds to pipeline flush.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  M-type instruction present in execute; sampled only in IDLE
i_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_src_a  input  WIDTH  forwarded rs1 value
i_src_b  input  WIDTH  forwarded rs2 value
i_flush  input  1  kill operation in progress
o_stall  output  1  freeze fetch/decode/execute
o_busy  output  1  FSM not in IDLE
o_done  output  1  o_result valid this cycle
o_result  output  WIDTH  result

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE, counter 0, o_done 0, o_busy 0, o_result 0, internal accumulators 0. Reset asserted mid-operation aborts immediately. No done is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE to CALC: on i_start && !i_flush. Latch i_op.
  - Multiply: latch |a| and |b| according to signedness. MULHSU treats only a as signed.
  - Divide: latch |dividend| and |divisor|.
  - Latch sign-fix flags and clear the counter.
- IDLE to DONE fast path, divide ops only:
  - Divisor zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- CALC: one iteration per cycle. Counter increments 0..WIDTH-1. At count WIDTH-1, go to DONE.
  - Multiply: 2*WIDTH-bit shift-add product.
  - Divide: restoring shift-subtract on a 2*WIDTH-bit remainder:quotient register.
- Sign fix on the CALC to DONE edge:
  - Product: negate if signs differ (signed ops only).
  - Quotient: negate if signs differ (DIV only).
  - Remainder: takes the dividend's sign (REM only).
- Result selection:
  - MUL returns the low WIDTH bits.
  - MULH/MULHSU/MULHU return the high WIDTH bits.
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
- DONE: o_done=1 for exactly one cycle, o_stall=0, o_result registered and stable. Then unconditionally back to IDLE. A new i_start is ignored in DONE because the pipeline advances that cycle.
- o_stall (combinational) = (IDLE && i_start && !i_flush) || CALC. It is asserted in the start cycle so the instruction stays in execute.
- Latency:
  - Normal op: i_start at cycle 0, o_done at cycle WIDTH+1 (33).
  - Fast path: o_done at cycle 1.
- i_start while not IDLE: ignored. Operand changes after cycle 0 have no effect.
- i_flush: in any state, next state IDLE, o_done forced 0 that cycle, o_stall 0. o_result retains its previous value. If i_flush and i_start coincide in IDLE, flush wins.
- o_result holds its last value outside DONE. Consumers must qualify with o_done.
- Width rules: all arithmetic is unsigned on magnitudes. Negation is two's complement modulo 2^WIDTH (or 2^(2*WIDTH) for the product). |0x80000000| = 0x80000000 unsigned.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> o_stall high cycles 0-32, o_done at cycle 33, o_result=0xFFFFFFEB; o_busy high cycles 1-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7,2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100,7 -> 2. Each with done at cycle 33.
- Fast paths:
  - DIVU 5/0 -> 0xFFFFFFFF with done at cycle 1.
  - REM 5,0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0. No CALC cycles in any case.
- Start DIV, assert i_flush at cycle 10 -> o_done never asserted, o_busy 0 at cycle 11, o_stall 0. New MUL 3x4 started at cycle 12 -> done at cycle 45, result 12.
- Drop i_rst_n mid-CALC (cycle 20), asynchronous to the clock -> o_busy/o_done/o_result 0 immediately. Toggle i_start during CALC -> no effect on result or timing. Flush+start same cycle -> stays IDLE.
